// File: rtl/intr_controller_if.sv
// Pipeline-facing bundle of the interrupt controller: raw request lines, ID-stage
// status in, flush/redirect controls and handler status out.
interface intr_controller_if #(
  parameter int N_IRQ    = 3,
  parameter int PC_WIDTH = 32
);
  logic [N_IRQ-1:0]    irq_in;
  logic [N_IRQ-1:0]    irq_mask;
  logic                id_valid;
  logic                pipe_stall;
  logic [PC_WIDTH-1:0] id_pc;
  logic                eret;
  logic                flush;
  logic                redirect_en;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] epc;
  logic                in_service;
  logic [1:0]          cur_irq;

  modport master (
    output irq_in, irq_mask, id_valid, pipe_stall, id_pc, eret,
    input  flush, redirect_en, redirect_pc, epc, in_service, cur_irq
  );

  modport slave (
    input  irq_in, irq_mask, id_valid, pipe_stall, id_pc, eret,
    output flush, redirect_en, redirect_pc, epc, in_service, cur_irq
  );
endinterface

// File: rtl/intr_controller.sv
// Single-level edge-triggered interrupt controller: synchronises request lines,
// waits for a safe ID-stage slot, then flushes and redirects to/from handlers.
module intr_controller #(
  parameter int                  N_IRQ      = 3,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] VEC_BASE   = 32'h0000_1000,
  parameter logic [PC_WIDTH-1:0] VEC_STRIDE = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           rst_n,
  intr_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TAKE,
    ST_SERVICE,
    ST_RETURN
  } state_e;

  state_e              state_q, state_d;
  logic [N_IRQ-1:0]    sync1_q, sync1_d;
  logic [N_IRQ-1:0]    sync2_q, sync2_d;
  logic [N_IRQ-1:0]    prev_q, prev_d;
  logic [N_IRQ-1:0]    pending_q, pending_d;
  logic                flush_q, flush_d;
  logic                redirect_en_q, redirect_en_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic                in_service_q, in_service_d;
  logic [1:0]          cur_irq_q, cur_irq_d;

  logic [N_IRQ-1:0]    rise;
  logic [N_IRQ-1:0]    eligible;
  logic [N_IRQ-1:0]    clr;
  logic [1:0]          sel;
  logic                safe_slot;

  always_comb begin
    sync1_d = bus.irq_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise     = sync2_q & ~prev_q;
    eligible = pending_q & ~bus.irq_mask;
    safe_slot = bus.id_valid && !bus.pipe_stall;

    // Walk downwards so the lowest eligible index wins.
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 2'(i);
    end

    state_d       = state_q;
    clr           = '0;
    flush_d       = 1'b0;
    redirect_en_d = 1'b0;
    redirect_pc_d = redirect_pc_q;
    epc_d         = epc_q;
    in_service_d  = in_service_q;
    cur_irq_d     = cur_irq_q;

    // Flush/redirect are decided one state early so they are registered
    // and visible exactly while the FSM sits in TAKE or RETURN.
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eligible == '0) begin
          state_d = ST_IDLE;
        end else if (safe_slot) begin
          epc_d         = bus.id_pc;
          cur_irq_d     = sel;
          clr           = {{(N_IRQ-1){1'b0}}, 1'b1} << sel;
          flush_d       = 1'b1;
          redirect_en_d = 1'b1;
          redirect_pc_d = VEC_BASE + PC_WIDTH'(sel) * VEC_STRIDE;
          state_d       = ST_TAKE;
        end
      end
      ST_TAKE: begin
        in_service_d = 1'b1;
        state_d      = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (bus.eret && safe_slot) begin
          flush_d       = 1'b1;
          redirect_en_d = 1'b1;
          redirect_pc_d = epc_q;
          state_d       = ST_RETURN;
        end
      end
      ST_RETURN: begin
        in_service_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge in the same cycle as the take keeps the bit pending.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      pending_q     <= '0;
      flush_q       <= 1'b0;
      redirect_en_q <= 1'b0;
      redirect_pc_q <= '0;
      epc_q         <= '0;
      in_service_q  <= 1'b0;
      cur_irq_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      flush_q       <= flush_d;
      redirect_en_q <= redirect_en_d;
      redirect_pc_q <= redirect_pc_d;
      epc_q         <= epc_d;
      in_service_q  <= in_service_d;
      cur_irq_q     <= cur_irq_d;
    end
  end

  assign bus.flush       = flush_q;
  assign bus.redirect_en = redirect_en_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.epc         = epc_q;
  assign bus.in_service  = in_service_q;
  assign bus.cur_irq     = cur_irq_q;

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: table of take/return scenarios plus hand-written
// priority, stalled-eret, mask and mid-take reset sequences.
module tb_intr_controller;
  localparam int N_IRQ = 3;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  intr_controller_if #(.N_IRQ(N_IRQ), .PC_WIDTH(PC_W)) bus ();

  intr_controller #(
    .N_IRQ(N_IRQ), .PC_WIDTH(PC_W),
    .VEC_BASE(32'h0000_1000), .VEC_STRIDE(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  irq;
    bit          take;
  } exp_t;

  typedef struct {
    int          line;
    logic [31:0] pc;
    int          stall;
    logic [31:0] vec;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t tbl[4];
  int   total = 0;
  int   bad   = 0;
  bit   prev_redir = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every redirect must match the next expected record, last one cycle, and carry flush.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_redir = 1'b0;
    end else begin
      if (bus.redirect_en) begin
        chk("redir_one_cycle", 32'(prev_redir), 32'd0);
        chk("flush_with_redir", 32'(bus.flush), 32'd1);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_redirect actual=%h required=none", bus.redirect_pc);
        end else begin
          mon_e = sbq.pop_front();
          chk(mon_e.take ? "take_redirect_pc" : "ret_redirect_pc", bus.redirect_pc, mon_e.pc);
          chk("redir_epc", bus.epc, mon_e.epc);
          if (mon_e.take) chk("take_cur_irq", 32'(bus.cur_irq), 32'(mon_e.irq));
        end
      end else if (bus.flush) begin
        chk("flush_without_redir", 32'(bus.flush), 32'd0);
      end
      prev_redir = bus.redirect_en;
    end
  end

  task automatic wait_is(input bit exp, input int budget, input string name);
    int n = 0;
    while (bus.in_service !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.in_service), 32'(exp));
  endtask

  task automatic do_take(input int line, input logic [31:0] pc, input int stall,
                         input logic [31:0] vec, input string name);
    int lat = 0;
    int exp_lat;
    bus.id_pc      = pc;
    bus.pipe_stall = (stall != 0);
    sbq.push_back('{pc: vec, epc: pc, irq: 2'(line), take: 1'b1});
    bus.irq_in[line] = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.redirect_en && lat == stall) bus.pipe_stall = 1'b0;
    end while (!bus.redirect_en && lat < 40);
    exp_lat = (stall == 0) ? 5 : stall + 1;
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    bus.irq_in[line] = 1'b0;
    bus.pipe_stall   = 1'b0;
    wait_is(1'b1, 10, {name, "_in_service"});
    chk({name, "_cur_irq"}, 32'(bus.cur_irq), 32'(line));
  endtask

  task automatic do_ret(input logic [31:0] epc_exp, input string name);
    sbq.push_back('{pc: epc_exp, epc: epc_exp, irq: 2'd0, take: 1'b0});
    bus.eret = 1'b1;
    @(negedge clk);
    bus.eret = 1'b0;
    wait_is(1'b0, 10, name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int lat;
    tbl[0] = '{line: 1, pc: 32'h0000_0040, stall: 0, vec: 32'h0000_1100};
    tbl[1] = '{line: 0, pc: 32'h0000_0200, stall: 0, vec: 32'h0000_1000};
    tbl[2] = '{line: 2, pc: 32'h0000_0080, stall: 5, vec: 32'h0000_1200};
    tbl[3] = '{line: 1, pc: 32'h0000_1234, stall: 7, vec: 32'h0000_1100};

    rst_n = 1'b0;
    bus.irq_in = '0; bus.irq_mask = '0; bus.id_valid = 1'b1;
    bus.pipe_stall = 1'b0; bus.id_pc = '0; bus.eret = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_redirect_en", 32'(bus.redirect_en), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_epc", bus.epc, 32'd0);
    chk("rst_in_service", 32'(bus.in_service), 32'd0);
    chk("rst_cur_irq", 32'(bus.cur_irq), 32'd0);

    // Quiet period after reset; eret in IDLE must not redirect.
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(bus.flush) + int'(bus.redirect_en) + int'(bus.in_service);
      bus.eret = (i >= 5 && i < 9);
    end
    bus.eret = 1'b0;
    chk("idle_quiet", 32'(cnt), 32'd0);
    chk("idle_epc", bus.epc, 32'd0);

    for (int t = 0; t < 4; t++) begin
      do_take(tbl[t].line, tbl[t].pc, tbl[t].stall, tbl[t].vec, $sformatf("tbl%0d", t));
      repeat (2) @(negedge clk);
      do_ret(tbl[t].pc, $sformatf("tbl%0d_ret", t));
      repeat (3) @(negedge clk);
    end

    // Lines 2 and 0 together: 0 first, 2 after the return.
    bus.id_pc = 32'h0000_0300;
    sbq.push_back('{pc: 32'h0000_1000, epc: 32'h0000_0300, irq: 2'd0, take: 1'b1});
    bus.irq_in = 3'b101;
    wait_is(1'b1, 20, "prio_first_in");
    chk("prio_first_irq", 32'(bus.cur_irq), 32'd0);
    bus.irq_in = 3'b000;
    bus.id_pc = 32'h0000_0304;
    do_ret(32'h0000_0300, "prio_first_ret");
    sbq.push_back('{pc: 32'h0000_1200, epc: 32'h0000_0304, irq: 2'd2, take: 1'b1});
    wait_is(1'b1, 20, "prio_second_in");
    chk("prio_second_irq", 32'(bus.cur_irq), 32'd2);
    do_ret(32'h0000_0304, "prio_second_ret");
    repeat (3) @(negedge clk);

    // eret held under stall; line-1 edge during service waits for the return.
    do_take(0, 32'h0000_0500, 0, 32'h0000_1000, "svc");
    bus.irq_in[1] = 1'b1;
    bus.eret = 1'b1;
    bus.pipe_stall = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(bus.redirect_en) + int'(!bus.in_service);
    end
    chk("svc_stall_hold", 32'(cnt), 32'd0);
    sbq.push_back('{pc: 32'h0000_0500, epc: 32'h0000_0500, irq: 2'd0, take: 1'b0});
    bus.pipe_stall = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.redirect_en && lat < 10);
    chk("svc_ret_latency", 32'(lat), 32'd1);
    bus.eret = 1'b0;
    bus.irq_in[1] = 1'b0;
    bus.id_pc = 32'h0000_0600;
    sbq.push_back('{pc: 32'h0000_1100, epc: 32'h0000_0600, irq: 2'd1, take: 1'b1});
    wait_is(1'b0, 10, "svc_ret_out");
    wait_is(1'b1, 20, "svc_pending_taken");
    chk("svc_pending_irq", 32'(bus.cur_irq), 32'd1);
    do_ret(32'h0000_0600, "svc_pending_ret");
    repeat (3) @(negedge clk);

    // Masked lines stay pending; unmask line 0, then reset during its TAKE.
    bus.irq_mask = 3'b101;
    bus.irq_in = 3'b101;
    repeat (6) @(negedge clk);
    bus.irq_in = 3'b000;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      cnt += int'(bus.redirect_en) + int'(bus.in_service);
    end
    chk("mask_no_take", 32'(cnt), 32'd0);
    bus.id_pc = 32'h0000_0700;
    sbq.push_back('{pc: 32'h0000_1000, epc: 32'h0000_0700, irq: 2'd0, take: 1'b1});
    bus.irq_mask = 3'b100;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.redirect_en && lat < 20);
    chk("unmask_take", 32'(bus.redirect_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_flush", 32'(bus.flush), 32'd0);
    chk("abort_redirect_en", 32'(bus.redirect_en), 32'd0);
    chk("abort_redirect_pc", bus.redirect_pc, 32'd0);
    chk("abort_epc", bus.epc, 32'd0);
    chk("abort_in_service", 32'(bus.in_service), 32'd0);
    chk("abort_cur_irq", 32'(bus.cur_irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.irq_mask = 3'b000;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(bus.redirect_en) + int'(bus.in_service);
    end
    chk("abort_pending_cleared", 32'(cnt), 32'd0);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Single-level, edge-triggered interrupt controller that sequences the pipeline's entry to and exit from interrupt handlers.
- Synchronises external request lines and holds pending bits. Waits for a safe point, indicated by the ID stage being valid and not bubbled. Captures the EPC, then issues a one-cycle flush plus PC redirect to a per-line vector.
- On eret, redirects back to the EPC. Sits beside the decode/control logic and drives the PC mux and the IF/ID flush.

Parameters:
- N_IRQ, 3, number of request lines; index 0 is the highest priority.
- PC_WIDTH, 32, program counter width.
- VEC_BASE, 32'h0000_1000, handler address for line 0.
- VEC_STRIDE, 32'h0000_0100, address spacing between handler vectors.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- irq_in  in  N_IRQ  raw request lines, asynchronous, level.
- irq_mask  in  N_IRQ  1 = line masked; the pending bit still sets but is not taken.
- id_valid  in  1  ID stage holds a real instruction.
- pipe_stall  in  1  hazard bubble from control; no take or return while high.
- id_pc  in  PC_WIDTH  PC of the instruction in ID; this instruction is squashed by flush.
- eret  in  1  ID instruction decodes as eret.
- flush  out  1  squash IF/ID contents, one cycle.
- redirect_en  out  1  select redirect_pc as next PC, one cycle.
- redirect_pc  out  PC_WIDTH  redirect target.
- epc  out  PC_WIDTH  saved return PC.
- in_service  out  1  handler active.
- cur_irq  out  2  index of the line being serviced.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; sync registers, edge register and pending all 0; flush=0; redirect_en=0; redirect_pc=0; epc=0; in_service=0; cur_irq=0. Reset asserted mid-operation aborts any in-flight take or return immediately.
- Input path: 2-FF synchroniser per line, followed by a previous-value register. A rising edge on the synchronised value sets pending[i].
- Latency: a pin rising before clock edge k sets pending at edge k+2.
- Pending bit clears only when its line is taken. If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- Eligible = pending & ~irq_mask. Selected line = lowest eligible index.
- All outputs are registered. The FSM uses 5 states: IDLE, WAIT, TAKE, SERVICE, RETURN.
  - IDLE: if eligible != 0 → WAIT. eret in IDLE is ignored (no redirect).
  - WAIT: if eligible == 0 (masked meanwhile) → IDLE. Else, if id_valid && !pipe_stall: epc<=id_pc, cur_irq<=selected, clear pending[selected], → TAKE. Priority is re-evaluated every WAIT cycle, so a higher-priority line arriving during WAIT is taken instead.
  - TAKE: flush=1, redirect_en=1, redirect_pc=VEC_BASE+cur_irq*VEC_STRIDE for exactly one cycle; in_service<=1; → SERVICE.
  - SERVICE: no nesting; new edges only set pending. If eret && id_valid && !pipe_stall → RETURN.
  - RETURN: flush=1, redirect_en=1, redirect_pc=epc for exactly one cycle; in_service<=0; → IDLE. A still-eligible pending line is taken via WAIT on a later cycle.
- flush and redirect_en are high only in TAKE and RETURN, and never for more than one consecutive cycle. redirect_pc holds its last value when redirect_en=0.
- Vector arithmetic is PC_WIDTH wide; overflow wraps modulo 2^PC_WIDTH.

Test Plan:
- Reset release, irq_in=0 for 20 cycles → flush, redirect_en and in_service stay 0; epc=0.
- irq_in[1] pulse, id_valid=1, pipe_stall=0, id_pc=0x0000_0040 → pending[1] set 2 edges after the pulse; one-cycle flush with redirect_pc=0x0000_1100; epc=0x40; cur_irq=1; in_service=1.
- irq_in[2] and irq_in[0] rise together → line 0 taken first (redirect 0x1000). After eret, line 2 taken (redirect 0x1200). Each redirect is one cycle.
- Interrupt pending with pipe_stall=1 for 5 cycles, id_pc=0x80 → no flush during the stall; take occurs on the first cycle with stall low; epc=0x80.
- In SERVICE, eret with pipe_stall=1, then with pipe_stall=0 → return only after the stall drops; redirect_pc=epc; in_service=0. A line-1 edge during SERVICE stays pending and is taken after the return.
- irq_mask[0]=1, irq_in[0] edge → no take. Clear the mask → taken. rst_n low during TAKE → all outputs 0 immediately, pending cleared.
